inject_scheduler: RTL and testbench
===================================

# inject_scheduler

Per-node injection scheduler that shares one PE node's router local input port (port 0) between several local packet sources. It sits between the PE-side traffic queues and the network's per-node `i_data`/`i_data_val`/`o_en` triple. It grants sources round-robin, registers the winning packet, and holds it stable until the router's local port enables a transfer. An optional token bucket limits the injection rate.

## Interface
Parameters:
- `SOURCES`, default 4: number of local requesters (≥2).
- `RATE_PERIOD`, default 8: cycles per token refill (≥1); used only with the rate limiter.
- `RATE_BURST`, default 2: token bucket depth (≥1); used only with the rate limiter.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `i_src_data`  in  `packet_t [0:SOURCES-1]`: packet offered by each source.
- `i_src_val`  in  `[0:SOURCES-1]`: source k is offering a packet.
- `o_src_ready`  out  `[0:SOURCES-1]`: source k's packet is accepted this cycle. One-hot or zero.
- `o_net_data`  out  `packet_t`: packet to the node's network `i_data` entry.
- `o_net_val`  out  1: drives the node's network `i_data_val` entry.
- `i_net_en`  in  1: the node's network `o_en` entry (router port-0 enable).
- `o_grant_id`  out  `$clog2(SOURCES)`: source index of the packet currently held.
- `o_inject_count`  out  16: number of completed network transfers.

## Operation
- **Holding register FSM**, two states:
  - EMPTY: `o_net_val`=0.
  - FULL: `o_net_val`=1; `o_net_data` and `o_grant_id` are stable.
- **Network transfer**: occurs on an edge where FULL and `i_net_en`=1.
- **Free slot** (`slot_free`) = EMPTY, or (FULL and `i_net_en`=1).
- **Arbitration** (combinational):
  - Among sources with `i_src_val`=1, pick the first at or after pointer `rr_ptr`, scanning upward with wrap.
  - `o_src_ready[w]`=1 only if `slot_free` is true (and a token is available when the rate limiter is compiled in).
- **Source accept** (`i_src_val[w]` and `o_src_ready[w]`):
  - Load the packet and index `w` into the register; state becomes FULL.
  - Set `rr_ptr` to (w+1) mod SOURCES.
- **Simultaneous transfer and accept**: the register is replaced by the new packet; state stays FULL. This is back-to-back operation with no bubble.
- **Transfer with no accept**: state becomes EMPTY.
- **`rr_ptr` moves only on accept.** Idle cycles do not rotate it.
- **`o_inject_count`**: +1 per network transfer; wraps from 0xFFFF to 0.
- **No valid source**: no ready is asserted and the register is unaffected.
- **Source with val=0**: it is never granted. Sources may drop val without a grant; no stickiness is required.

## Timing
- Reset values:
  - `o_net_val`=0, `o_net_data`='0, `o_grant_id`=0, `o_inject_count`=0.
  - `rr_ptr`=0; state EMPTY.
  - Tokens = RATE_BURST; refill counter = 0.
- **Latency**: a packet accepted at edge t is on `o_net_val`/`o_net_data` in the cycle after edge t.
- **Throughput**: 1 packet/cycle while `i_net_en`=1 continuously (limiter absent).
- `o_src_ready` depends combinationally on `i_src_val`, `i_net_en` and state. There is no path from `o_src_ready` back into the inputs.
- **Backpressure**: with `i_net_en`=0 and FULL, all ready=0 and the held packet is stable for any duration.
- **Reset mid-operation**: the held packet is discarded without transfer, and all state returns to reset values on the next edge.

## Configuration
- Macro: `INJECT_RATE_LIMIT_EN`.
- **Defined** (token bucket active):
  - Refill counter counts 0..RATE_PERIOD-1 and wraps. Each wrap adds one token, saturating at RATE_BURST.
  - Each accept consumes one token. Accept is allowed only when tokens>0.
  - Refill and consume on the same edge: the count is unchanged.
- **Undefined**: counter and tokens are absent; the grant condition is `slot_free` only.

## Structure
- Shared constants go in `config.sv`:
  - `packet_t` (already present).
  - `INJ_SOURCES` default, `INJ_RATE_PERIOD`, `INJ_RATE_BURST`.
- Sub-module `rr_arbiter`:
  - Combinational priority scan from `rr_ptr`, plus the pointer register with update-on-accept.
  - Parameterised by `SOURCES`; reusable by router switch allocation.
- Top level contains the holding-register FSM, counters and optional token bucket.

## Test plan
- **Single source, always ready:**
  - Stimulus: src2 val with packets A,B,C; `i_net_en`=1 throughout.
  - Expected: ready[2] on 3 consecutive cycles; `o_net_val`=1 for 3 cycles, one cycle later, carrying A,B,C; `o_grant_id`=2; `o_inject_count`=3.
- **Fairness:**
  - Stimulus: all 4 sources val continuously, from reset.
  - Expected: grant order 0,1,2,3,0,1… with no source granted twice before the others.
- **Backpressure:**
  - Stimulus: FULL with packet P; `i_net_en`=0 for 5 cycles.
  - Expected: P stable; all ready=0; count unchanged; P transfers on the first `i_net_en`=1 edge, with a new accept on the same edge.
- **Skip idle:**
  - Stimulus: `rr_ptr`=1; only src3 and src0 val.
  - Expected: src3 granted first, then src0; `rr_ptr` ends at 1.
- **Reset mid-operation:**
  - Stimulus: `reset_n`=0 for one edge while FULL.
  - Expected: `o_net_val`=0, count=0, `rr_ptr`=0 afterwards; P is never transferred.
- **Rate limit** (`INJECT_RATE_LIMIT_EN`, PERIOD=8, BURST=2):
  - Stimulus: one source val continuously.
  - Expected: 2 accepts on cycles 0–1, then 1 accept every 8 cycles; tokens never exceed 2.

Source files
------------

// File: rtl/inject_scheduler_pkg.sv
// Shared types and default sizing for the local injection scheduler.
package inject_scheduler_pkg;

  typedef struct packed {
    logic [3:0]  dest;
    logic [11:0] payload;
  } packet_t;

  localparam int INJ_SOURCES     = 4;
  localparam int INJ_RATE_PERIOD = 8;
  localparam int INJ_RATE_BURST  = 2;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/inject_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational scan upward from rr_ptr with wrap.
// The pointer moves to one past the winner only when a grant is taken.
module rr_arbiter #(
  parameter int SOURCES = 4,
  localparam int IW = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [0:SOURCES-1]   req,
  input  logic                 enable,
  output logic [0:SOURCES-1]   grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 accept
);

  logic [IW-1:0] rr_ptr;
  logic          found;

  always_comb begin
    int j;
    found     = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int i = 0; i < SOURCES; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= SOURCES) j = j - SOURCES;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant_idx = IW'(j);
      end
    end
    accept = found && enable;
    grant  = '0;
    if (accept) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == IW'(SOURCES - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/inject_scheduler.sv
// Shares the router local input port between SOURCES requesters via a one-deep holding register.
// Optional token-bucket rate limiter enabled by INJECT_RATE_LIMIT_EN.
module inject_scheduler
  import inject_scheduler_pkg::*;
#(
  parameter int SOURCES     = INJ_SOURCES,
  parameter int RATE_PERIOD = INJ_RATE_PERIOD,
  parameter int RATE_BURST  = INJ_RATE_BURST,
  localparam int IW = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  packet_t            i_src_data [SOURCES],
  input  logic [0:SOURCES-1] i_src_val,
  output logic [0:SOURCES-1] o_src_ready,
  output packet_t            o_net_data,
  output logic               o_net_val,
  input  logic               i_net_en,
  output logic [IW-1:0]      o_grant_id,
  output logic [15:0]        o_inject_count
);

  hold_state_t   state;
  logic          slot_free;
  logic          xfer;
  logic          grant_ok;
  logic          accept;
  logic [IW-1:0] win_idx;

  assign slot_free = (state == HOLD_EMPTY) || i_net_en;
  assign xfer      = (state == HOLD_FULL) && i_net_en;
  assign o_net_val = (state == HOLD_FULL);

`ifdef INJECT_RATE_LIMIT_EN
  localparam int TW = $clog2(RATE_BURST + 1);
  localparam int CW = (RATE_PERIOD > 1) ? $clog2(RATE_PERIOD) : 1;

  logic [TW-1:0] tokens;
  logic [CW-1:0] refill_cnt;
  logic          refill;

  assign refill   = (refill_cnt == CW'(RATE_PERIOD - 1));
  assign grant_ok = slot_free && (tokens != '0);

  // A refill landing on a consuming edge cancels out, even when saturated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tokens     <= TW'(RATE_BURST);
      refill_cnt <= '0;
    end else begin
      refill_cnt <= refill ? '0 : refill_cnt + CW'(1);
      if (refill && !accept) begin
        if (tokens < TW'(RATE_BURST)) tokens <= tokens + TW'(1);
      end else if (accept && !refill) begin
        tokens <= tokens - TW'(1);
      end
    end
  end
`else
  logic unused_rate_cfg;
  assign unused_rate_cfg = ^{32'(RATE_PERIOD), 32'(RATE_BURST)};
  assign grant_ok        = slot_free;
`endif

  rr_arbiter #(.SOURCES(SOURCES)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (i_src_val),
    .enable    (grant_ok),
    .grant     (o_src_ready),
    .grant_idx (win_idx),
    .accept    (accept)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= HOLD_EMPTY;
      o_net_data     <= '0;
      o_grant_id     <= '0;
      o_inject_count <= '0;
    end else begin
      if (xfer) o_inject_count <= o_inject_count + 16'd1;
      if (accept) begin
        state      <= HOLD_FULL;
        o_net_data <= i_src_data[win_idx];
        o_grant_id <= win_idx;
      end else if (xfer) begin
        state <= HOLD_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_inject_scheduler.sv
// Directed bench for inject_scheduler with hand-computed expectations.
module tb_inject_scheduler;
  import inject_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  packet_t     src_data [4];
  logic [0:3]  src_val;
  logic [0:3]  src_ready;
  packet_t     net_data;
  logic        net_val;
  logic        net_en;
  logic [1:0]  grant_id;
  logic [15:0] inject_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inject_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_src_data     (src_data),
    .i_src_val      (src_val),
    .o_src_ready    (src_ready),
    .o_net_data     (net_data),
    .o_net_val      (net_val),
    .i_net_en       (net_en),
    .o_grant_id     (grant_id),
    .o_inject_count (inject_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:3] oh(input int k);
    logic [0:3] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] src_pkt(input int k);
    return 16'h5A00 | 16'(k);
  endfunction

  logic [15:0] pk [3];

  initial begin
    pk[0] = 16'hA001;
    pk[1] = 16'hB002;
    pk[2] = 16'hC003;
    reset_n = 1'b0;
    src_val = '0;
    net_en  = 1'b0;
    for (int k = 0; k < 4; k++) src_data[k] = '0;
    cyc();
    cyc();
    check("rst_val", 32'(net_val), 0);
    check("rst_data", 32'(net_data), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_cnt", 32'(inject_count), 0);
    check("rst_rdy", 32'(src_ready), 0);
    reset_n = 1'b1;

`ifdef INJECT_RATE_LIMIT_EN
    src_data[0] = 16'h1234;
    src_val[0]  = 1'b1;
    net_en      = 1'b1;
    for (int c = 0; c < 26; c++) begin
      #1;
      check("rate_rdy", 32'(src_ready),
            32'(((c < 2) || (c >= 8 && c % 8 == 0)) ? oh(0) : 4'b0000));
      cyc();
    end
    src_val = '0;
`else
    // Single source, back-to-back
    net_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_data[2] = pk[k];
      src_val     = '0;
      src_val[2]  = 1'b1;
      #1;
      check("t1_rdy", 32'(src_ready), 32'(oh(2)));
      check("t1_val", 32'(net_val), (k > 0) ? 1 : 0);
      if (k > 0) check("t1_data", 32'(net_data), 32'(pk[k-1]));
      cyc();
    end
    src_val = '0;
    #1;
    check("t1_last", 32'(net_data), 32'(pk[2]));
    check("t1_gid", 32'(grant_id), 2);
    check("t1_rdy0", 32'(src_ready), 0);
    check("t1_cnt2", 32'(inject_count), 2);
    cyc();
    check("t1_empty", 32'(net_val), 0);
    check("t1_cnt3", 32'(inject_count), 3);

    // Fairness from reset
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) src_data[k] = src_pkt(k);
    src_val = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fair_rdy", 32'(src_ready), 32'(oh(i % 4)));
      cyc();
      check("fair_gid", 32'(grant_id), 32'(i % 4));
      check("fair_data", 32'(net_data), 32'(src_pkt(i % 4)));
    end

    // Backpressure holding source 3's packet
    net_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rdy", 32'(src_ready), 0);
      cyc();
      check("bp_val", 32'(net_val), 1);
      check("bp_data", 32'(net_data), 32'(src_pkt(3)));
      check("bp_cnt", 32'(inject_count), 7);
    end
    net_en = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(src_ready), 32'(oh(0)));
    cyc();
    check("bp_rel_cnt", 32'(inject_count), 8);
    check("bp_rel_gid", 32'(grant_id), 0);

    // Skip idle sources starting from pointer 1
    src_val    = '0;
    src_val[3] = 1'b1;
    src_val[0] = 1'b1;
    #1;
    check("skip_rdy3", 32'(src_ready), 32'(oh(3)));
    cyc();
    check("skip_gid3", 32'(grant_id), 3);
    #1;
    check("skip_rdy0", 32'(src_ready), 32'(oh(0)));
    cyc();
    check("skip_gid0", 32'(grant_id), 0);
    src_val = 4'b1111;
    #1;
    check("skip_ptr1", 32'(src_ready), 32'(oh(1)));
    cyc();
    check("skip_cnt", 32'(inject_count), 11);
    check("skip_gid1", 32'(grant_id), 1);

    // Reset while holding source 1's packet
    src_val = '0;
    net_en  = 1'b0;
    reset_n = 1'b0;
    cyc();
    check("mrst_val", 32'(net_val), 0);
    check("mrst_cnt", 32'(inject_count), 0);
    check("mrst_gid", 32'(grant_id), 0);
    check("mrst_data", 32'(net_data), 0);
    reset_n = 1'b1;
    net_en  = 1'b1;
    cyc();
    check("mrst_noxfer_val", 32'(net_val), 0);
    check("mrst_noxfer_cnt", 32'(inject_count), 0);
    src_val[0] = 1'b1;
    src_val[3] = 1'b1;
    #1;
    check("mrst_ptr0", 32'(src_ready), 32'(oh(0)));
    src_val = '0;
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
